fifo_rd_packer: RTL

- Read-side consumer of the async FIFO, in the rclk domain.
- Pops DSIZE-bit entries via rinc/rempty and packs LANES consecutive entries into one wide word.
- Presents each packed word downstream on a valid/ready interface.
- A flush request emits a partial word with a byte-lane keep mask, so short tails do not stall.

---
 rtl/fifo_rd_packer.sv | 102 ++++++++++
 1 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: pops DSIZE-bit entries and packs LANES of them
// into one wide word on a valid/ready output; a flush emits a partial word with a keep mask.
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int LANES = 4,
    parameter int CW    = 2
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    input  logic                   rempty,
    input  logic [DSIZE-1:0]       rdata,
    output logic                   rinc,
    input  logic                   flush,
    output logic [DSIZE*LANES-1:0] out_data,
    output logic [LANES-1:0]       out_keep,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int AW = DSIZE * (LANES - 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(LANES - 1);

    logic [AW-1:0]          r_acc;
    logic [CW-1:0]          r_cnt;
    logic                   r_flush_pend;
    logic [DSIZE*LANES-1:0] r_out_data;
    logic [LANES-1:0]       r_out_keep;
    logic                   r_out_last;
    logic                   r_out_valid;

    logic                   w_out_free;
    logic                   w_cnt_top;
    logic                   w_pop;
    logic                   w_full_load;
    logic                   w_flush_emit;
    logic [LANES-1:0]       w_keep_part;

    assign w_out_free   = !r_out_valid || out_ready;
    assign w_cnt_top    = (r_cnt == CNT_TOP);
    // Gating with rrst_n keeps the pop strobe quiet for the whole reset window.
    assign w_pop        = rrst_n && !rempty && !r_flush_pend && !(w_cnt_top && !w_out_free);
    assign w_full_load  = w_pop && w_cnt_top;
    assign w_flush_emit = r_flush_pend && w_out_free && (r_cnt != '0);
    assign w_keep_part  = LANES'((1 << r_cnt) - 1);

    assign rinc      = w_pop;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign busy      = (r_cnt != '0) || r_out_valid || r_flush_pend;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_full_load || w_flush_emit) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_pop) begin
            r_acc[r_cnt*DSIZE +: DSIZE] <= rdata;
            r_cnt                       <= r_cnt + CW'(1);
        end
    end

    // A load in the same cycle as a handshake replaces the word, so no bubble is needed.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_full_load) begin
            r_out_data  <= {rdata, r_acc};
            r_out_keep  <= '1;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b1;
        end else if (w_flush_emit) begin
            r_out_data  <= {{DSIZE{1'b0}}, r_acc};
            r_out_keep  <= w_keep_part;
            r_out_last  <= 1'b1;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_flush_pend <= 1'b0;
        end else if (r_flush_pend) begin
            if (w_out_free) begin
                r_flush_pend <= 1'b0;
            end
        end else if (flush) begin
            r_flush_pend <= 1'b1;
        end
    end

endmodule
